// File: rtl/uart_word_transmitter.sv
// UART word transmitter: 32-bit words queue in a small FIFO and go out as four
// frames (start, 8 data LSB-first, XOR parity, stop), least-significant byte first.
module uart_word_transmitter #(
   parameter int unsigned CLK_PER_BIT = 192,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned GAP_BITS    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        word_valid,
   input  logic [31:0] word_data,
   output logic        word_ready,
   output logic        uart_tx,
   output logic        busy,
   output logic [31:0] words_sent
);
   localparam int unsigned WORD_W   = 32;
   localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned GAP_CYC  = GAP_BITS * CLK_PER_BIT;
   localparam int unsigned MAX_CYC  = (GAP_CYC > CLK_PER_BIT) ? GAP_CYC : CLK_PER_BIT;
   localparam int unsigned TICK_W   = $clog2(MAX_CYC + 1);
   localparam int unsigned BIT_LAST = CLK_PER_BIT - 1;
   localparam int unsigned GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
   localparam bit          NO_GAP   = (GAP_BITS == 0);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
   } state_e;

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [2:0]          bit_idx_q, bit_idx_d;
   logic [1:0]          byte_idx_q, byte_idx_d;
   logic                tx_q, tx_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic [WORD_W-1:0]   ws_q, ws_d;

   logic                push_c, pop_c, fifo_empty_c;
   logic                tick_end_c, last_byte_c, word_end_c, reload_c;
   logic [7:0]          cur_byte_c;

   assign push_c       = word_valid && ready_q;
   assign fifo_empty_c = (count_q == '0);
   assign tick_end_c   = (state_q == S_GAP) ? (tick_q == TICK_W'(GAP_LAST))
                                            : (tick_q == TICK_W'(BIT_LAST));
   assign last_byte_c  = (byte_idx_q == 2'd3);
   assign word_end_c   = (state_q == S_STOP) && tick_end_c && last_byte_c;
   assign cur_byte_c   = word_q[{byte_idx_q, 3'b000} +: 8];

   // A new word is launched from IDLE, after the gap, or straight after the last stop bit when there is no gap.
   assign reload_c = !fifo_empty_c &&
                     ((state_q == S_IDLE) ||
                      ((state_q == S_GAP) && tick_end_c) ||
                      (word_end_c && NO_GAP));
   assign pop_c    = reload_c;

   // FIFO bookkeeping; power-of-two depth lets the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
   end

   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q] <= word_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (reload_c) state_d = S_START;
         S_START:  if (tick_end_c) state_d = S_DATA;
         S_DATA:   if (tick_end_c && (bit_idx_q == 3'd7)) state_d = S_PARITY;
         S_PARITY: if (tick_end_c) state_d = S_STOP;
         S_STOP: begin
            if (tick_end_c) begin
               if (!last_byte_c || reload_c) state_d = S_START;
               else if (!NO_GAP)             state_d = S_GAP;
               else                          state_d = S_IDLE;
            end
         end
         S_GAP:    if (tick_end_c) state_d = reload_c ? S_START : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath next values: line level, bit/byte indices, bit timer, word counter.
   always_comb begin
      tick_d     = tick_end_c ? '0 : tick_q + TICK_W'(1);
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      tx_d       = tx_q;
      ws_d       = ws_q;
      unique case (state_q)
         S_IDLE: begin
            tick_d = '0;
            tx_d   = 1'b1;
         end
         S_START:  if (tick_end_c) tx_d = cur_byte_c[0];
         S_DATA: begin
            if (tick_end_c) begin
               if (bit_idx_q == 3'd7) begin
                  tx_d = ^cur_byte_c;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = cur_byte_c[bit_idx_d];
               end
            end
         end
         S_PARITY: if (tick_end_c) tx_d = 1'b1;
         S_STOP: begin
            if (tick_end_c) begin
               bit_idx_d = '0;
               if (!last_byte_c) begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  tx_d       = 1'b0;
               end else begin
                  ws_d = ws_q + WORD_W'(1);
                  tx_d = 1'b1;
               end
            end
         end
         S_GAP:    tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
      if (reload_c) begin
         word_d     = mem_q[rd_ptr_q];
         byte_idx_d = '0;
         bit_idx_d  = '0;
         tick_d     = '0;
         tx_d       = 1'b0;
      end
      ready_d = (count_d != CNT_W'(FIFO_DEPTH));
      busy_d  = (state_d != S_IDLE) || (count_d != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         word_q     <= '0;
         tick_q     <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         tx_q       <= 1'b1;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         ws_q       <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         word_q     <= word_d;
         tick_q     <= tick_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         tx_q       <= tx_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         ws_q       <= ws_d;
      end
   end

   assign word_ready = ready_q;
   assign uart_tx    = tx_q;
   assign busy       = busy_q;
   assign words_sent = ws_q;

endmodule

// File: tb/tb_uart_word_transmitter.sv
// Bench for uart_word_transmitter: line decoder + scoreboard, with a second
// instance built without the inter-word gap.
module tb_uart_word_transmitter;
   localparam int CPB      = 16;
   localparam int DEPTH    = 4;
   localparam int NVEC     = 5;
   localparam int BYTE_CYC = 11 * CPB;
   localparam int WORD_CYC = 4 * BYTE_CYC;
   localparam int WORD_PER = WORD_CYC + CPB;

   typedef struct packed {
      logic [31:0]      word;
      logic [3:0][7:0]  bytes;   // bytes[0] is sent first
      logic [3:0]       par;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        word_valid, v0;
   logic [31:0] word_data, d0;
   logic        word_ready, ready0;
   logic        uart_tx, tx0;
   logic        busy, busy0;
   logic [31:0] words_sent, ws0;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   vec_t vec [NVEC];
   vec_t exp_q [$];
   int   start_q [$];
   bit   rx_en   = 1'b0;
   bit   rx_busy = 1'b0;
   int   rx_byte_cnt = 0;
   int   rx_prev_start = 0;
   int   rx_words = 0;
   logic [31:0] rx_word = '0;

   uart_word_transmitter #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .GAP_BITS(1)) u_dut (
      .clk(clk), .rst(rst), .word_valid(word_valid), .word_data(word_data),
      .word_ready(word_ready), .uart_tx(uart_tx), .busy(busy), .words_sent(words_sent));

   uart_word_transmitter #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .GAP_BITS(0)) u_dut_g0 (
      .clk(clk), .rst(rst), .word_valid(v0), .word_data(d0),
      .word_ready(ready0), .uart_tx(tx0), .busy(busy0), .words_sent(ws0));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: cycle %0d reached without finishing, limit 200000", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Mid-bit sampling line decoder; compares each frame with the scoreboard head.
   task automatic rx_frame();
      logic [7:0] data;
      logic       par, stp, stb;
      bit         aborted;
      int         st;
      vec_t       e;
      rx_busy = 1'b1;
      aborted = 1'b0;
      st = cyc;
      if (rx_byte_cnt == 0) start_q.push_back(st);
      else chk("byte_spacing", 32'(st - rx_prev_start), 32'(BYTE_CYC));
      rx_prev_start = st;
      repeat (CPB / 2) @(negedge clk);
      stb = uart_tx;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk);
         data[i] = uart_tx;
         if (!rx_en) aborted = 1'b1;
      end
      repeat (CPB) @(negedge clk);
      par = uart_tx;
      repeat (CPB) @(negedge clk);
      stp = uart_tx;
      if (!rx_en) aborted = 1'b1;
      if (aborted) begin
         rx_byte_cnt = 0;
      end else begin
         chk("start_bit", 32'(stb), 32'd0);
         chk("stop_bit", 32'(stp), 32'd1);
         if (exp_q.size() == 0) begin
            chk("unexpected_byte", 32'(data), 32'hFFFF_FFFF);
         end else begin
            e = exp_q[0];
            chk("rx_byte", 32'(data), 32'(e.bytes[rx_byte_cnt]));
            chk("rx_parity", 32'(par), 32'(e.par[rx_byte_cnt]));
            rx_word[8*rx_byte_cnt +: 8] = data;
            rx_byte_cnt++;
            if (rx_byte_cnt == 4) begin
               chk("rx_word", rx_word, e.word);
               void'(exp_q.pop_front());
               rx_byte_cnt = 0;
               rx_words++;
            end
         end
      end
      rx_busy = 1'b0;
   endtask

   always begin
      @(negedge clk);
      if (rx_en && uart_tx === 1'b0) rx_frame();
   end

   task automatic push_word(input vec_t v, output int push_edge, output int waited);
      @(negedge clk);
      word_valid = 1'b1;
      word_data  = v.word;
      waited     = 0;
      while (word_ready !== 1'b1 && waited < 4 * WORD_PER) begin
         @(negedge clk);
         waited++;
      end
      if (word_ready !== 1'b1) chk("push_timeout", 32'(word_ready), 32'd1);
      else exp_q.push_back(v);
      push_edge = cyc + 1;
      @(posedge clk);
   endtask

   task automatic drop_valid();
      @(negedge clk);
      word_valid = 1'b0;
   endtask

   task automatic wait_ws(input logic [31:0] target, input int max_cyc, output int edge_cyc);
      int n = 0;
      while (words_sent !== target && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      edge_cyc = cyc;
      chk("words_sent", words_sent, target);
   endtask

   task automatic wait_idle(input int max_cyc, output int edge_cyc);
      int n = 0;
      while (busy !== 1'b0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      edge_cyc = cyc;
      chk("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      int pe, pe2, we, ie, waited, p0, s0, n, fall_cyc;
      bit ok;
      logic [31:0] base;

      vec[0] = '{word: 32'h1234_5678, bytes: {8'h12, 8'h34, 8'h56, 8'h78}, par: 4'b0100};
      vec[1] = '{word: 32'h0000_0013, bytes: {8'h00, 8'h00, 8'h00, 8'h13}, par: 4'b0001};
      vec[2] = '{word: 32'hFFDF_F06F, bytes: {8'hFF, 8'hDF, 8'hF0, 8'h6F}, par: 4'b0100};
      vec[3] = '{word: 32'hFFFF_FFFF, bytes: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, par: 4'b0000};
      vec[4] = '{word: 32'h0000_0000, bytes: {8'h00, 8'h00, 8'h00, 8'h00}, par: 4'b0000};

      rst = 1'b1; word_valid = 1'b0; word_data = '0; v0 = 1'b0; d0 = '0;
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(uart_tx), 32'd1);
      chk("rst_ready", 32'(word_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_words_sent", words_sent, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(word_ready), 32'd1);
      rx_en = 1'b1;

      // Single words from the table, each sent from idle
      start_q.delete();
      for (int i = 0; i < NVEC; i++) begin
         push_word(vec[i], pe, waited);
         drop_valid();
         if (i == 0) begin
            chk("busy_after_push", 32'(busy), 32'd1);
            chk("tx_before_start", 32'(uart_tx), 32'd1);
            @(negedge clk);
            chk("tx_start_edge", 32'(uart_tx), 32'd0);
         end
         wait_ws(32'(i + 1), WORD_CYC + 20, we);
         if (i == 0) begin
            chk("first_start", 32'(start_q[0]), 32'(pe + 1));
            chk("ws_latency", 32'(we - pe), 32'(1 + WORD_CYC));
         end
         wait_idle(2 * CPB, ie);
         chk("gap_then_idle", 32'(ie - we), 32'(CPB));
      end
      chk("rx_words_table", 32'(rx_words), 32'(NVEC));

      // FIFO_DEPTH+1 back-to-back pushes
      start_q.delete();
      base = words_sent;
      for (int i = 0; i < DEPTH + 1; i++) begin
         push_word(vec[i], pe, waited);
         if (i == 0) p0 = pe;
         chk("push_no_wait", 32'(waited), 32'd0);
      end
      drop_valid();
      chk("ready_full", 32'(word_ready), 32'd0);
      n = 0;
      while (word_ready !== 1'b1 && n < 2 * WORD_PER) begin
         @(negedge clk);
         n++;
      end
      chk("ready_reassert", 32'(cyc - (p0 + 1)), 32'(WORD_PER));
      wait_ws(base + 32'(DEPTH + 1), (DEPTH + 2) * WORD_PER, we);
      wait_idle(2 * CPB, ie);
      chk("b2b_word_count", 32'(start_q.size()), 32'(DEPTH + 1));
      if (start_q.size() == DEPTH + 1) begin
         chk("b2b_first_start", 32'(start_q[0]), 32'(p0 + 1));
         for (int i = 1; i < DEPTH + 1; i++)
            chk("word_spacing", 32'(start_q[i] - start_q[i-1]), 32'(WORD_PER));
      end
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      // Reset during DATA bit 3 of byte 2, with a second word queued
      start_q.delete();
      push_word(vec[4], pe, waited);
      push_word(vec[1], pe2, waited);
      drop_valid();
      while (cyc < pe + 1 + 2 * BYTE_CYC + 4 * CPB + CPB / 2) @(negedge clk);
      chk("tx_mid_bit3", 32'(uart_tx), 32'd0);
      rx_en = 1'b0;
      rst   = 1'b1;
      #1;
      chk("abort_tx", 32'(uart_tx), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(word_ready), 32'd0);
      chk("abort_words_sent", words_sent, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("abort_ready_back", 32'(word_ready), 32'd1);
      ok = 1'b1;
      repeat (3 * CPB) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      end
      chk("fifo_flushed", 32'(ok), 32'd1);
      n = 0;
      while (rx_busy && n < 20 * CPB) begin
         @(negedge clk);
         n++;
      end
      start_q.delete();
      rx_en = 1'b1;
      push_word(vec[0], pe, waited);
      drop_valid();
      wait_ws(32'd1, WORD_CYC + 20, we);
      chk("restart_start", (start_q.size() > 0) ? 32'(start_q[0]) : 32'hFFFF_FFFF, 32'(pe + 1));
      chk("restart_latency", 32'(we - pe), 32'(1 + WORD_CYC));
      wait_idle(2 * CPB, ie);

      // No-gap instance: two queued words run back-to-back
      @(negedge clk);
      chk("g0_ready", 32'(ready0), 32'd1);
      v0 = 1'b1; d0 = vec[0].word; p0 = cyc + 1;
      @(negedge clk);
      d0 = vec[1].word;
      @(negedge clk);
      v0 = 1'b0;
      s0 = p0 + 1;
      ok = 1'b1;
      fall_cyc = -1;
      while (cyc < s0 + 2 * WORD_CYC + 3) begin
         if (cyc >= s0 && cyc < s0 + 2 * WORD_CYC && busy0 !== 1'b1) ok = 1'b0;
         if (cyc >= s0 && fall_cyc < 0 && busy0 === 1'b0) fall_cyc = cyc;
         if (cyc == s0 + WORD_CYC - 1) chk("g0_stop_bit", 32'(tx0), 32'd1);
         if (cyc == s0 + WORD_CYC) begin
            chk("g0_b2b_start", 32'(tx0), 32'd0);
            chk("g0_ws_first", ws0, 32'd1);
         end
         @(negedge clk);
      end
      chk("g0_busy_hold", 32'(ok), 32'd1);
      chk("g0_busy_fall", 32'(fall_cyc - s0), 32'(2 * WORD_CYC));
      chk("g0_ws_second", ws0, 32'd2);

      // words_sent wrap
      @(negedge clk);
      force u_dut.ws_q = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      release u_dut.ws_q;
      @(negedge clk);
      chk("ws_preload", words_sent, 32'hFFFF_FFFF);
      push_word(vec[2], pe, waited);
      drop_valid();
      wait_ws(32'd0, WORD_CYC + 20, we);
      chk("ws_wrap_latency", 32'(we - pe), 32'(1 + WORD_CYC));
      wait_idle(2 * CPB, ie);
      chk("scoreboard_final", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
